hazard_scoreboard: RTL
======================

// Module: hazard_scoreboard
// PURPOSE
//  Parametrised hazard unit for the MIPS pipeline; generalises the fixed 5-stage HCU.
//  Tracks each in-flight register write as a {dst, tnew} entry that counts down per stage.
//  Produces the ID stall, and forward selects for ID and EX consumers.
//  Contains an internal mult/div latency timer, so it no longer needs external start/busy.
//  Keeps a saturating stall-cycle counter for performance measurement.
// PARAMETERS
//  NSTAGE    3   tracked stages after ID (entry 1 = EX, 2 = MEM, 3 = WB, ...)
//  REG_AW    5   register index width
//  TW        3   tuse/tnew width; all-ones tuse = TUSE_NONE (operand unused)
//  MULT_LAT  5   busy cycles for mult/multu
//  DIV_LAT   10  busy cycles for div/divu
// PORTS
//  clk          in   1            clock
//  reset        in   1            synchronous, active-high
//  id_valid     in   1            ID holds a real instruction
//  id_rs,id_rt  in   REG_AW       ID source registers
//  id_tuse_rs   in   TW           cycles until rs is needed (0 = in ID)
//  id_tuse_rt   in   TW           same for rt
//  id_dst       in   REG_AW       ID destination register; 0 = no write
//  id_tnew      in   TW           cycles, counted from EX entry, until result can be forwarded
//  id_md_use    in   1            ID instruction is mult/div/mfhi/mflo/mthi/mtlo
//  id_md_start  in   1            ID instruction starts mult/div
//  id_md_div    in   1            start is a divide (selects DIV_LAT)
//  flush        in   1            kill the ID instruction this cycle
//  stall        out  1            hold PC/IF/ID and insert a bubble into EX
//  fwd_id_rs    out  FW           0 = regfile, k = entry k (FW = clog2(NSTAGE+1))
//  fwd_id_rt    out  FW
//  fwd_ex_rs    out  FW           0 = no forward, k >= 2 = entry k
//  fwd_ex_rt    out  FW
//  md_busy      out  1            HI/LO unit busy
//  stall_cnt    out  32           stall cycles, saturating
// BEHAVIOUR
//  Reset:
//   - all entries become bubbles (dst = 0); ex_rs/ex_rt = 0; md timer = 0; stall_cnt = 0.
//   - all outputs read 0. Reset mid-operation aborts the md timer immediately.
//  Advance (every cycle, never stalled itself):
//   - e[k+1] <= {e[k].dst, sat_dec(e[k].t)}; e[NSTAGE] falls off.
//   - e[1] <= {id_dst, id_tnew} when id_valid & !stall & !flush; otherwise a bubble.
//   - ex_rs/ex_rt <= id_rs/id_rt on the same condition; otherwise 0.
//  Match rule:
//   - entry k matches source s when e[k].dst != 0 && e[k].dst == s.
//   - Only the youngest match (lowest k) is used.
//  Stall:
//   - raw = youngest rs match t > id_tuse_rs, or the same for rt.
//   - A source whose tuse is TUSE_NONE never stalls.
//   - raw also asserts when id_md_use && md_busy.
//   - stall = raw & id_valid & !flush. stall is combinational, same cycle.
//  fwd_id_*:
//   - k when the youngest match has t == 0; otherwise 0.
//   - A pending match with 0 < t <= tuse returns 0; the EX select covers it later.
//  fwd_ex_*: the youngest match among entries 2..NSTAGE with t == 0; else 0.
//  MD timer:
//   - Load happens on id_md_start & id_valid & !stall & !flush.
//   - The timer loads DIV_LAT when id_md_div = 1, MULT_LAT otherwise.
//   - It decrements to 0; md_busy = (timer != 0).
//   - md_busy is high for exactly LAT cycles starting the cycle after issue.
//  stall_cnt: +1 each cycle stall = 1; holds at 32'hFFFF_FFFF.
//  Simultaneous flush and hazard: flush wins; stall = 0, e[1] gets a bubble, no md load.
// STRUCTURE
//  Shared package hazard_pkg:
//   - TUSE_NONE, the bubble entry constant, and the entry typedef {dst, t}.
//   - A function fw_width(NSTAGE).
//  Sub-module hazard_src_match (combinational priority finder).
//   - Inputs: source register, entry array, low index.
//   - Outputs: hit, k, t.
//   - Instantiated four times (id rs/rt, ex rs/rt).
//  The top level holds the entry shift register, ex_rs/ex_rt regs, md timer and stall counter.
// TESTING
//  1. lw $1 (tnew=2), then beq $1,$0 (tuse_rs=0):
//     stall is high for 2 cycles, then fwd_id_rs = 3, then stall = 0.
//  2. addu $2 (tnew=1), then addu $4,$2,$3 (tuse=1): no stall, fwd_id_rs = 0;
//     next cycle fwd_ex_rs = 2.
//  3. jal $31 (tnew=0) in e[2] and addu $31 (tnew=0) in e[1], then jr $31: fwd_id_rs = 1.
//  4. id_dst = 0 with tnew = 2, then a reader of $0: stall = 0, fwd = 0.
//  5. mult (MULT_LAT=5), then mflo: md_busy is high 5 cycles, stall is high 5 cycles,
//     stall_cnt = 5; div gives 10.
//  6. flush while a load-use stall is pending: stall = 0, next e[1] is a bubble,
//     stall_cnt unchanged. Reset mid-div: md_busy = 0 the next cycle.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and helpers for the scoreboard-based hazard unit.
// Entry widths are fixed here; the top-level REG_AW/TW defaults track them.
package hazard_pkg;

    localparam int HZ_REG_AW = 5;
    localparam int HZ_TW     = 3;

    // A consumer whose tuse is all-ones does not read that operand.
    localparam logic [HZ_TW-1:0] TUSE_NONE = '1;

    typedef struct packed {
        logic [HZ_REG_AW-1:0] dst;
        logic [HZ_TW-1:0]     t;
    } entry_t;

    localparam entry_t BUBBLE = '{dst: '0, t: '0};

    function automatic int fw_width(input int nstage);
        return $clog2(nstage + 1);
    endfunction

    function automatic logic [HZ_TW-1:0] sat_dec(input logic [HZ_TW-1:0] t);
        return (t == '0) ? t : t - HZ_TW'(1);
    endfunction

endpackage

// File: rtl/hazard_src_match.sv
// Priority finder: youngest scoreboard entry at or above index lo that writes src.
module hazard_src_match
    import hazard_pkg::*;
#(
    parameter int NSTAGE = 3,
    parameter int FW     = fw_width(NSTAGE)
) (
    input  logic [HZ_REG_AW-1:0] src,
    input  entry_t               ent [1:NSTAGE],
    input  logic [FW-1:0]        lo,
    output logic                 hit,
    output logic [FW-1:0]        k,
    output logic [HZ_TW-1:0]     t
);

    // Scan oldest to youngest so the lowest matching index wins.
    always_comb begin
        hit = 1'b0;
        k   = '0;
        t   = '0;
        for (int unsigned i = NSTAGE; i >= 1; i--) begin
            if (i >= 32'(lo) && ent[i].dst != '0 && ent[i].dst == src) begin
                hit = 1'b1;
                k   = FW'(i);
                t   = ent[i].t;
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Parametrised MIPS hazard unit: countdown scoreboard of in-flight writes,
// ID stall, ID/EX forward selects, internal mult/div timer and stall counter.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NSTAGE   = 3,
    parameter int REG_AW   = HZ_REG_AW,
    parameter int TW       = HZ_TW,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          id_valid,
    input  logic [REG_AW-1:0]             id_rs,
    input  logic [REG_AW-1:0]             id_rt,
    input  logic [TW-1:0]                 id_tuse_rs,
    input  logic [TW-1:0]                 id_tuse_rt,
    input  logic [REG_AW-1:0]             id_dst,
    input  logic [TW-1:0]                 id_tnew,
    input  logic                          id_md_use,
    input  logic                          id_md_start,
    input  logic                          id_md_div,
    input  logic                          flush,
    output logic                          stall,
    output logic [fw_width(NSTAGE)-1:0]   fwd_id_rs,
    output logic [fw_width(NSTAGE)-1:0]   fwd_id_rt,
    output logic [fw_width(NSTAGE)-1:0]   fwd_ex_rs,
    output logic [fw_width(NSTAGE)-1:0]   fwd_ex_rt,
    output logic                          md_busy,
    output logic [31:0]                   stall_cnt
);

    localparam int FW     = fw_width(NSTAGE);
    localparam int MD_MAX = (DIV_LAT > MULT_LAT) ? DIV_LAT : MULT_LAT;
    localparam int MDW    = $clog2(MD_MAX + 1);

    entry_t            ent [1:NSTAGE];
    logic [REG_AW-1:0] ex_rs;
    logic [REG_AW-1:0] ex_rt;
    logic [MDW-1:0]    md_timer;

    logic          id_hit_rs, id_hit_rt, ex_hit_rs, ex_hit_rt;
    logic [FW-1:0] id_k_rs, id_k_rt, ex_k_rs, ex_k_rt;
    logic [TW-1:0] id_t_rs, id_t_rt, ex_t_rs, ex_t_rt;
    logic          raw;
    logic          issue;

    hazard_src_match #(.NSTAGE(NSTAGE), .FW(FW)) u_id_rs (
        .src(id_rs), .ent(ent), .lo(FW'(1)), .hit(id_hit_rs), .k(id_k_rs), .t(id_t_rs)
    );
    hazard_src_match #(.NSTAGE(NSTAGE), .FW(FW)) u_id_rt (
        .src(id_rt), .ent(ent), .lo(FW'(1)), .hit(id_hit_rt), .k(id_k_rt), .t(id_t_rt)
    );
    // EX consumers skip entry 1, which is the EX instruction itself.
    hazard_src_match #(.NSTAGE(NSTAGE), .FW(FW)) u_ex_rs (
        .src(ex_rs), .ent(ent), .lo(FW'(2)), .hit(ex_hit_rs), .k(ex_k_rs), .t(ex_t_rs)
    );
    hazard_src_match #(.NSTAGE(NSTAGE), .FW(FW)) u_ex_rt (
        .src(ex_rt), .ent(ent), .lo(FW'(2)), .hit(ex_hit_rt), .k(ex_k_rt), .t(ex_t_rt)
    );

    assign md_busy = (md_timer != '0);

    always_comb begin
        raw = 1'b0;
        if (id_hit_rs && id_tuse_rs != TUSE_NONE && id_t_rs > id_tuse_rs) raw = 1'b1;
        if (id_hit_rt && id_tuse_rt != TUSE_NONE && id_t_rt > id_tuse_rt) raw = 1'b1;
        if (id_md_use && md_busy) raw = 1'b1;
        stall = raw && id_valid && !flush;
        issue = id_valid && !stall && !flush;
    end

    always_comb begin
        fwd_id_rs = (id_hit_rs && id_t_rs == '0) ? id_k_rs : '0;
        fwd_id_rt = (id_hit_rt && id_t_rt == '0) ? id_k_rt : '0;
        fwd_ex_rs = (ex_hit_rs && ex_t_rs == '0) ? ex_k_rs : '0;
        fwd_ex_rt = (ex_hit_rt && ex_t_rt == '0) ? ex_k_rt : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 1; i <= NSTAGE; i++) ent[i] <= BUBBLE;
            ex_rs <= '0;
            ex_rt <= '0;
        end else begin
            for (int unsigned i = 2; i <= NSTAGE; i++)
                ent[i] <= '{dst: ent[i-1].dst, t: sat_dec(ent[i-1].t)};
            if (issue) begin
                ent[1] <= '{dst: id_dst, t: id_tnew};
                ex_rs  <= id_rs;
                ex_rt  <= id_rt;
            end else begin
                ent[1] <= BUBBLE;
                ex_rs  <= '0;
                ex_rt  <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            md_timer <= '0;
        end else if (issue && id_md_start) begin
            md_timer <= id_md_div ? MDW'(DIV_LAT) : MDW'(MULT_LAT);
        end else if (md_timer != '0) begin
            md_timer <= md_timer - MDW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (stall && stall_cnt != '1) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

endmodule
